// File: rtl/delay_tap_trainer.sv
// Delay-line tap trainer: sweeps every tap, finds the widest passing window and parks the tap at its centre.
// Optional feature: define TRAINER_PASSMAP_EN to add the per-tap pass_map result output.
module delay_tap_trainer #(
    parameter int TAP_W      = 5,
    parameter int SETTLE_CYC = 4,
    parameter int SAMPLES    = 8,
    parameter int EXP_LAT    = 1,
    parameter int MIN_WIN    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sampled,
    output logic             pattern,
    output logic [TAP_W-1:0] tap,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [TAP_W-1:0] win_lo,
    output logic [TAP_W-1:0] win_hi,
    output logic [TAP_W-1:0] center
`ifdef TRAINER_PASSMAP_EN
    ,
    output logic [(2**TAP_W)-1:0] pass_map
`endif
);

    localparam int CNT_MAX = (SETTLE_CYC > SAMPLES) ? SETTLE_CYC : SAMPLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLES - 1);
    localparam logic [TAP_W-1:0] TAP_MAX     = {TAP_W{1'b1}};
    localparam logic [TAP_W-1:0] TAP_ZERO    = {TAP_W{1'b0}};
    localparam logic [TAP_W:0]   LEN_ZERO    = {(TAP_W+1){1'b0}};
    localparam logic [TAP_W:0]   LEN_ONE     = {{TAP_W{1'b0}}, 1'b1};
    localparam logic [TAP_W:0]   MIN_WIN_LEN = (TAP_W+1)'(MIN_WIN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_EVAL   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [EXP_LAT-1:0] exp_pipe_r;
    logic               exp_s;
    logic               tap_fail_r;
    logic               tap_pass_s;

    logic               pattern_r;
    logic [TAP_W-1:0]   tap_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [TAP_W-1:0]   win_lo_r;
    logic [TAP_W-1:0]   win_hi_r;
    logic [TAP_W-1:0]   center_r;

    logic               run_open_r, run_open_s;
    logic [TAP_W-1:0]   run_lo_r, run_lo_s;
    logic [TAP_W:0]     run_len_r, run_len_s;
    logic [TAP_W-1:0]   best_lo_r, best_lo_s;
    logic [TAP_W-1:0]   best_hi_r, best_hi_s;
    logic [TAP_W:0]     best_len_r, best_len_s;
    logic               close_s;
    logic [TAP_W-1:0]   close_lo_s;
    logic [TAP_W-1:0]   close_hi_s;
    logic [TAP_W:0]     close_len_s;
    logic [TAP_W:0]     sum_s;
    logic [TAP_W-1:0]   center_s;
    logic               win_ok_s;

`ifdef TRAINER_PASSMAP_EN
    logic [(2**TAP_W)-1:0] pass_map_r;
    assign pass_map = pass_map_r;
`endif

    assign pattern    = pattern_r;
    assign tap        = tap_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign win_lo     = win_lo_r;
    assign win_hi     = win_hi_r;
    assign center     = center_r;
    assign exp_s      = exp_pipe_r[EXP_LAT-1];
    assign tap_pass_s = ~tap_fail_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_SETTLE;
                else       state_s = S_IDLE;
            end
            S_SETTLE: begin
                if (cnt_r == SETTLE_LAST) state_s = S_SAMPLE;
                else                      state_s = S_SETTLE;
            end
            S_SAMPLE: begin
                if (cnt_r == SAMPLE_LAST) state_s = S_EVAL;
                else                      state_s = S_SAMPLE;
            end
            S_EVAL: begin
                if (tap_r == TAP_MAX) state_s = S_FINISH;
                else                  state_s = S_SETTLE;
            end
            S_FINISH: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Run/best window tracking evaluated in the EVAL cycle; the last tap also closes an open run at N-1
    always_comb begin
        run_open_s  = run_open_r;
        run_lo_s    = run_lo_r;
        run_len_s   = run_len_r;
        best_lo_s   = best_lo_r;
        best_hi_s   = best_hi_r;
        best_len_s  = best_len_r;
        close_s     = 1'b0;
        close_lo_s  = run_lo_r;
        close_hi_s  = tap_r;
        close_len_s = run_len_r;
        if (state_r == S_EVAL) begin
            if (tap_pass_s) begin
                if (run_open_r) begin
                    run_len_s = run_len_r + LEN_ONE;
                end else begin
                    run_lo_s  = tap_r;
                    run_len_s = LEN_ONE;
                end
                run_open_s = 1'b1;
                if (tap_r == TAP_MAX) begin
                    close_s     = 1'b1;
                    close_lo_s  = run_lo_s;
                    close_hi_s  = tap_r;
                    close_len_s = run_len_s;
                    run_open_s  = 1'b0;
                end else begin
                    close_s = 1'b0;
                end
            end else begin
                run_open_s = 1'b0;
                if (run_open_r) begin
                    close_s     = 1'b1;
                    close_lo_s  = run_lo_r;
                    close_hi_s  = tap_r - {{(TAP_W-1){1'b0}}, 1'b1};
                    close_len_s = run_len_r;
                end else begin
                    close_s = 1'b0;
                end
            end
        end else begin
            close_s = 1'b0;
        end
        // Strictly longer replaces, so on a tie the earlier (lower) window survives
        if (close_s && (close_len_s > best_len_r)) begin
            best_lo_s  = close_lo_s;
            best_hi_s  = close_hi_s;
            best_len_s = close_len_s;
        end else begin
            best_len_s = best_len_r;
        end
    end

    assign sum_s    = {1'b0, best_lo_s} + {1'b0, best_hi_s};
    assign center_s = TAP_W'(sum_s >> 1);
    assign win_ok_s = (best_len_s >= MIN_WIN_LEN);

    // Expected-data pipeline: pattern delayed by the launch-to-capture latency
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_pipe_r <= {EXP_LAT{1'b0}};
        end else begin
            exp_pipe_r[0] <= pattern_r;
            for (int i = 1; i < EXP_LAT; i++) begin
                exp_pipe_r[i] <= exp_pipe_r[i-1];
            end
        end
    end

    // Sequencer datapath: counters, compare flag, trackers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            tap_fail_r <= 1'b0;
            pattern_r  <= 1'b0;
            tap_r      <= TAP_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            win_lo_r   <= TAP_ZERO;
            win_hi_r   <= TAP_ZERO;
            center_r   <= TAP_ZERO;
            run_open_r <= 1'b0;
            run_lo_r   <= TAP_ZERO;
            run_len_r  <= LEN_ZERO;
            best_lo_r  <= TAP_ZERO;
            best_hi_r  <= TAP_ZERO;
            best_len_r <= LEN_ZERO;
`ifdef TRAINER_PASSMAP_EN
            pass_map_r <= {(2**TAP_W){1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            if (state_s != state_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        busy_r     <= 1'b1;
                        tap_r      <= TAP_ZERO;
                        pass_r     <= 1'b0;
                        win_lo_r   <= TAP_ZERO;
                        win_hi_r   <= TAP_ZERO;
                        center_r   <= TAP_ZERO;
                        run_open_r <= 1'b0;
                        run_lo_r   <= TAP_ZERO;
                        run_len_r  <= LEN_ZERO;
                        best_lo_r  <= TAP_ZERO;
                        best_hi_r  <= TAP_ZERO;
                        best_len_r <= LEN_ZERO;
`ifdef TRAINER_PASSMAP_EN
                        pass_map_r <= {(2**TAP_W){1'b0}};
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    pattern_r  <= ~pattern_r;
                    tap_fail_r <= 1'b0;
                end
                S_SAMPLE: begin
                    pattern_r <= ~pattern_r;
                    if (sampled !== exp_s) begin
                        tap_fail_r <= 1'b1;
                    end else begin
                        tap_fail_r <= tap_fail_r;
                    end
                end
                S_EVAL: begin
                    pattern_r  <= ~pattern_r;
                    run_open_r <= run_open_s;
                    run_lo_r   <= run_lo_s;
                    run_len_r  <= run_len_s;
                    best_lo_r  <= best_lo_s;
                    best_hi_r  <= best_hi_s;
                    best_len_r <= best_len_s;
`ifdef TRAINER_PASSMAP_EN
                    pass_map_r[tap_r] <= tap_pass_s;
`endif
                    if (tap_r != TAP_MAX) begin
                        tap_r <= tap_r + {{(TAP_W-1){1'b0}}, 1'b1};
                    end else begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        if (win_ok_s) begin
                            pass_r   <= 1'b1;
                            win_lo_r <= best_lo_s;
                            win_hi_r <= best_hi_s;
                            center_r <= center_s;
                            tap_r    <= center_s;
                        end else begin
                            pass_r   <= 1'b0;
                            win_lo_r <= TAP_ZERO;
                            win_hi_r <= TAP_ZERO;
                            center_r <= TAP_ZERO;
                            tap_r    <= TAP_ZERO;
                        end
                    end
                end
                S_FINISH: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_tap_trainer.sv
// Scoreboard bench for delay_tap_trainer (TAP_W=3, SETTLE_CYC=2, SAMPLES=4, EXP_LAT=1, MIN_WIN=2: P=7, done 57 cycles after start).
module tb_delay_tap_trainer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sampled;
    logic       pattern;
    logic [2:0] tap;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] win_lo;
    logic [2:0] win_hi;
    logic [2:0] center;
`ifdef TRAINER_PASSMAP_EN
    logic [7:0] pass_map;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    logic [7:0] pm_cfg      = 8'h00;
    bit         inj         = 1'b0;
    int         inj_cnt     = 0;

    typedef struct {
        int due;
        int pass;
        int lo;
        int hi;
        int ctr;
        int tap;
        int pm;
    } exp_t;

    exp_t sb_q[$];

    delay_tap_trainer #(
        .TAP_W(3), .SETTLE_CYC(2), .SAMPLES(4), .EXP_LAT(1), .MIN_WIN(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sampled(sampled),
        .pattern(pattern), .tap(tap), .busy(busy), .done(done), .pass(pass),
        .win_lo(win_lo), .win_hi(win_hi), .center(center)
`ifdef TRAINER_PASSMAP_EN
        , .pass_map(pass_map)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Capture-flop model: passing taps return pattern one cycle later, failing taps return X
    initial begin
        logic       p;
        logic [2:0] t;
        logic       b;
        logic       drv;
        sampled = 1'b0;
        forever begin
            @(negedge clk);
            p = pattern;
            t = tap;
            b = busy;
            if (pm_cfg[t]) drv = p;
            else           drv = 1'bx;
            if (inj && b && (t == 3'd4)) begin
                inj_cnt++;
                if (inj_cnt == 4) drv = ~p;
            end
            @(posedge clk);
            #1;
            sampled = drv;
        end
    end

    // Monitor: every done pulse pops one expected result
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", int'(done), 0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_cycle", cyc, e.due);
                    check("busy_at_done", int'(busy), 0);
                    check("pass", int'(pass), e.pass);
                    check("win_lo", int'(win_lo), e.lo);
                    check("win_hi", int'(win_hi), e.hi);
                    check("center", int'(center), e.ctr);
                    check("final_tap", int'(tap), e.tap);
`ifdef TRAINER_PASSMAP_EN
                    check("pass_map", int'(pass_map), e.pm);
`endif
                end
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check("done_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic push_exp(input int due, input int e_pass, input int e_lo, input int e_hi,
                            input int e_c, input logic [7:0] e_pm);
        exp_t e;
        e.due  = due;
        e.pass = e_pass;
        e.lo   = e_lo;
        e.hi   = e_hi;
        e.ctr  = e_c;
        e.tap  = e_c;
        e.pm   = int'(e_pm);
        sb_q.push_back(e);
    endtask

    task automatic run_case(input string name, input logic [7:0] map, input bit inject,
                            input int e_pass, input int e_lo, input int e_hi, input int e_c,
                            input logic [7:0] e_pm);
        @(negedge clk);
        pm_cfg  = map;
        inj     = inject;
        inj_cnt = 0;
        start   = 1'b1;
        push_exp(cyc + 57, e_pass, e_lo, e_hi, e_c, e_pm);
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy1"}, int'(busy), 1);
        check({name, "_tap1"}, int'(tap), 0);
        check({name, "_clr_pass"}, int'(pass), 0);
        check({name, "_clr_win"}, int'({win_lo, win_hi, center}), 0);
        wait_drain();
        inj = 1'b0;
    endtask

    initial begin
        int c0;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tap", int'(tap), 0);
        check("rst_pattern", int'(pattern), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_win", int'({win_lo, win_hi, center}), 0);
        rst = 1'b0;

        run_case("win2to5",  8'b0011_1100, 1'b0, 1, 2, 5, 3, 8'b0011_1100);
        run_case("later",    8'b0111_0011, 1'b0, 1, 4, 6, 5, 8'b0111_0011);
        run_case("allpass",  8'hFF,        1'b0, 1, 0, 7, 3, 8'hFF);
        run_case("tie",      8'b1110_0111, 1'b0, 1, 0, 2, 1, 8'b1110_0111);
        run_case("single",   8'b0000_1000, 1'b0, 0, 0, 0, 0, 8'b0000_1000);
        run_case("allfail",  8'h00,        1'b0, 0, 0, 0, 0, 8'h00);
        run_case("wrongval", 8'b0111_1000, 1'b1, 1, 5, 6, 5, 8'b0110_1000);

        // Mid-sweep reset, then a restart with an ignored second start
        @(negedge clk);
        pm_cfg = 8'b0011_1100;
        start  = 1'b1;
        c0     = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_tap", int'(tap), 0);
        check("midrst_pattern", int'(pattern), 0);
        check("midrst_done", int'(done), 0);
        while (cyc < c0 + 30) @(negedge clk);
        start = 1'b1;
        push_exp(c0 + 87, 1, 2, 5, 3, 8'b0011_1100);
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 35) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", int'(busy), 1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
